nor_stim_checker: RTL and testbench
===================================

# nor_stim_checker

Self-running stimulus generator and response checker for the three-input NOR gate stage. On `start` it drives every input combination onto `A`, `B`, `C`, waits a programmable settle time, samples the gate output `y`, and compares it with the expected NOR value. It sits directly upstream of the gate, which it feeds, and directly downstream of it, consuming `y`. This gives the gate an on-chip, clocked self-test in place of a hand-written `#100` stimulus sequence.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 4: number of cycles inputs are held before `y` is sampled; legal range 1..255.
- `VECTORS`, default 8: number of input combinations applied, starting at 0; legal range 1..8.

Ports:
- `clk`  in  1  single clock; every flop is rising-edge triggered.
- `rst_n`  in  1  reset, **synchronous, active-low**.
- `start`  in  1  one-cycle request to run a test pass; ignored while `busy`=1.
- `A`  out  1  gate input, vector bit 2; registered.
- `B`  out  1  gate input, vector bit 1; registered.
- `C`  out  1  gate input, vector bit 0; registered.
- `y`  in  1  gate output under check.
- `busy`  out  1  high from the cycle after `start` is accepted until DONE is entered.
- `done`  out  1  level; high in DONE and held until the next accepted `start` or reset.
- `pass`  out  1  valid while `done`=1; 1 when `err_count`==0.
- `err_count`  out  4  mismatch count, saturating at 15.
- `last_fail_vec`  out  3  {A,B,C} of the most recent mismatch; 0 when none.

## Operation
- FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE or DONE with `start`=1: clear `vec`, `err_count`, `last_fail_vec`, `done` and `pass`, then go to DRIVE.
- DRIVE: register {A,B,C} <= `vec`, load the settle counter with SETTLE_CYCLES-1, then go to SETTLE.
- SETTLE: decrement the counter; go to CHECK on the cycle the counter is 0.
- CHECK: compare `y` with expected = ~(A|B|C).
  - On mismatch: `err_count` <= min(`err_count`+1, 15) and `last_fail_vec` <= `vec`.
  - If `vec`==VECTORS-1, go to DONE. Otherwise increment `vec` and go to DRIVE.
- DONE: `done`=1 and `pass`=(`err_count`==0). {A,B,C} return to 000. Stay in DONE until `start`.
- Reset values: state IDLE. A, B, C, `busy`, `done`, `pass`, `err_count`, `last_fail_vec` all 0.
- Reset asserted mid-run aborts the pass on the next clock edge and restores all reset values. No partial result is retained.
- `start` while `busy`=1 has no effect. `start` in the same cycle as DONE entry is not seen; only a `start` sampled while in DONE restarts the pass.
- `vec` is 3 bits wide. There is no wrap-around, because VECTORS ≤ 8 bounds it.

## Timing
- `start` is sampled at edge 0. `busy`=1 and the FSM is in DRIVE after edge 0. {A,B,C}=vec0 after edge 1.
- Each vector occupies SETTLE_CYCLES+2 cycles: 1 DRIVE cycle, SETTLE_CYCLES SETTLE cycles, 1 CHECK cycle.
- `y` is sampled at the end of CHECK, which is SETTLE_CYCLES+1 cycles after the inputs change.
- `done` rises VECTORS·(SETTLE_CYCLES+2)+1 cycles after the `start` edge. With the defaults this is 49 cycles.
- `busy` falls in the same cycle that `done` rises.

## Configuration
- Macro `NOR_CHK_HALT_ON_ERR_EN`.
- When defined: the first mismatch in CHECK goes straight to DONE with `err_count`=1 and `last_fail_vec` set. No later vectors are applied.
- When undefined: every vector is always applied and mismatches accumulate as described in Operation.

## Structure
- Shared package `nor_chk_pkg`:
  - state encoding constants for IDLE, DRIVE, SETTLE, CHECK, DONE;
  - `ERR_MAX` = 15;
  - widths `VEC_W` = 3 and `ERR_W` = 4.
- One sub-module, `nor_chk_settle_cnt`: the loadable down-counter with zero flag. All other logic is flat in the top.

## Test plan
- Correct NOR gate connected, defaults, pulse `start` → {A,B,C} steps 000..111, `done` at cycle 49, `pass`=1, `err_count`=0, `last_fail_vec`=000.
- Gate model with `y` stuck at 0 → mismatch only at vector 000: `err_count`=1, `last_fail_vec`=000, `pass`=0.
- Gate model with `y` stuck at 1 → 7 mismatches: `err_count`=7, `last_fail_vec`=111. With `NOR_CHK_HALT_ON_ERR_EN` defined: `done` at cycle 13, `err_count`=1, `last_fail_vec`=001.
- `rst_n`=0 for one cycle at cycle 20 of a run → after that edge all outputs are 0 and state is IDLE. A fresh `start` completes normally.
- Extra `start` pulse at cycle 10 during a run → ignored and the pass is unchanged; `start` while in DONE → `done` clears and a new 49-cycle pass runs.
- Boundary: SETTLE_CYCLES=1, VECTORS=1, pulse `start` → only 000 applied, `done` at cycle 4, `pass`=1.

Source files
------------

// File: rtl/nor_chk_pkg.sv
// rtl/nor_chk_pkg.sv - shared states, widths and limits for the NOR gate self-test
package nor_chk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int VEC_W   = 3;
    localparam int ERR_W   = 4;
    localparam int ERR_MAX = 15;

endpackage

// File: rtl/nor_chk_settle_cnt.sv
// rtl/nor_chk_settle_cnt.sv - loadable settle down-counter with zero flag
module nor_chk_settle_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/nor_stim_checker.sv
// rtl/nor_stim_checker.sv - NOR gate stimulus/checker; optional NOR_CHK_HALT_ON_ERR_EN
module nor_stim_checker
    import nor_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int VECTORS       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             A,
    output logic             B,
    output logic             C,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [VEC_W-1:0] last_fail_vec
);

    state_t           state, state_next;
    logic [VEC_W-1:0] vec;
    logic             cnt_zero;
    logic             accept;
    logic             mismatch;
    logic             last_vec;

    // A start that lands while the result is still being published is dropped
    assign accept   = start && !busy && (state == ST_IDLE || state == ST_DONE);
    assign mismatch = (state == ST_CHECK) && (y != ~(A | B | C));
    assign last_vec = (vec == VEC_W'(VECTORS - 1));

    nor_chk_settle_cnt #(.W(8)) u_settle_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == ST_DRIVE),
        .load_val (8'(SETTLE_CYCLES - 1)),
        .dec      (state == ST_SETTLE),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (accept) state_next = ST_DRIVE;
            ST_DRIVE:  state_next = ST_SETTLE;
            ST_SETTLE: if (cnt_zero) state_next = ST_CHECK;
            ST_CHECK: begin
`ifdef NOR_CHK_HALT_ON_ERR_EN
                if (mismatch || last_vec) state_next = ST_DONE;
`else
                if (last_vec) state_next = ST_DONE;
`endif
                else state_next = ST_DRIVE;
            end
            ST_DONE:   if (accept) state_next = ST_DRIVE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec           <= '0;
            {A, B, C}     <= 3'b000;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            last_fail_vec <= '0;
        end else if (accept) begin
            vec           <= '0;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            last_fail_vec <= '0;
        end else begin
            case (state)
                ST_DRIVE: {A, B, C} <= vec;
                ST_CHECK: begin
                    if (mismatch) begin
                        if (err_count != ERR_W'(ERR_MAX)) err_count <= err_count + 1'b1;
                        last_fail_vec <= vec;
                    end
                    if (state_next == ST_DRIVE) vec <= vec + 1'b1;
                    else {A, B, C} <= 3'b000;
                end
                // Result is published one cycle after DONE is entered
                ST_DONE: begin
                    if (busy) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= (err_count == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nor_stim_checker.sv
// tb/tb_nor_stim_checker.sv - self-checking bench for nor_stim_checker
module tb_nor_stim_checker;

    localparam int S0 = 4;
    localparam int V0 = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic [7:0] fault_mask = 8'h00;

    logic       a0, b0, c0, y0, busy0, done0, pass0;
    logic [3:0] err0;
    logic [2:0] lfv0;
    logic       a1, b1, c1, y1, busy1, done1, pass1;
    logic [3:0] err1;
    logic [2:0] lfv1;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    // Gate model: correct NOR, with per-vector output inversion injected by fault_mask
    assign y0 = ~(a0 | b0 | c0) ^ fault_mask[{a0, b0, c0}];
    assign y1 = ~(a1 | b1 | c1);

    nor_stim_checker #(.SETTLE_CYCLES(S0), .VECTORS(V0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .A(a0), .B(b0), .C(c0), .y(y0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .last_fail_vec(lfv0)
    );

    nor_stim_checker #(.SETTLE_CYCLES(1), .VECTORS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1), .C(c1), .y(y1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .last_fail_vec(lfv1)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a0, b0, c0, busy0, done0, pass0, err0, lfv0} !== 13'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %b required 0", {a0, b0, c0, busy0, done0, pass0, err0, lfv0});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_pass(input string name, input logic [7:0] mask, input int extra_at);
        int nv, exp_err, exp_last, exp_done, n, first;
        logic halt;
`ifdef NOR_CHK_HALT_ON_ERR_EN
        halt = 1'b1;
`else
        halt = 1'b0;
`endif
        fault_mask = mask;
        first = -1; exp_err = 0; exp_last = 0;
        for (int k = 0; k < V0; k++) begin
            if (mask[k]) begin
                if (first < 0) first = k;
                exp_err++;
                exp_last = k;
            end
        end
        if (exp_err > 15) exp_err = 15;
        nv = V0;
        if (halt && first >= 0) begin
            nv = first + 1; exp_err = 1; exp_last = first;
        end
        exp_done = nv * (S0 + 2) + 1;

        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        checks++;
        if (busy0 !== 1'b1 || done0 !== 1'b0) begin
            fails++;
            $display("FAIL %s start_accept: busy=%b done=%b required busy=1 done=0", name, busy0, done0);
        end
        n = 0;
        while (n < 300) begin
            @(posedge clk);
            n++;
            #1;
            start0 = (n + 1 == extra_at);
            if (n >= 1 && (n - 1) % (S0 + 2) == 0 && (n - 1) / (S0 + 2) < nv) begin
                checks++;
                if ({a0, b0, c0} !== 3'((n - 1) / (S0 + 2))) begin
                    fails++;
                    $display("FAIL %s vector_drive@%0d: got %b required %0d", name, n, {a0, b0, c0}, (n - 1) / (S0 + 2));
                end
            end
            if (done0) break;
            if (busy0 !== 1'b1) begin
                checks++;
                fails++;
                $display("FAIL %s busy_during_run@%0d: got %b required 1", name, n, busy0);
            end
        end
        start0 = 1'b0;
        checks++;
        if (n !== exp_done) begin
            fails++;
            $display("FAIL %s done_cycle: got %0d required %0d", name, n, exp_done);
        end
        checks++;
        if (err0 !== 4'(exp_err) || lfv0 !== 3'(exp_last) || pass0 !== (exp_err == 0)) begin
            fails++;
            $display("FAIL %s result: err=%0d last=%0d pass=%b required err=%0d last=%0d pass=%b",
                     name, err0, lfv0, pass0, exp_err, exp_last, exp_err == 0);
        end
        checks++;
        if (busy0 !== 1'b0 || {a0, b0, c0} !== 3'b000) begin
            fails++;
            $display("FAIL %s done_idle: busy=%b abc=%b required busy=0 abc=000", name, busy0, {a0, b0, c0});
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (done0 !== 1'b1) begin
            fails++;
            $display("FAIL %s done_held: got %b required 1", name, done0);
        end
    endtask

    task automatic test_midrun_reset();
        fault_mask = 8'h00;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (n == 19) rst_n = 1'b0;
        end
        checks++;
        if ({a0, b0, c0, busy0, done0, pass0, err0, lfv0} !== 13'd0) begin
            fails++;
            $display("FAIL midrun_reset: got %b required 0", {a0, b0, c0, busy0, done0, pass0, err0, lfv0});
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0) begin
            fails++;
            $display("FAIL midrun_reset_idle: busy=%b done=%b required 0 0", busy0, done0);
        end
    endtask

    task automatic test_boundary();
        int n;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        n = 0;
        while (n < 50) begin
            @(posedge clk);
            n++;
            #1;
            if (n == 1) begin
                checks++;
                if ({a1, b1, c1} !== 3'b000 || busy1 !== 1'b1) begin
                    fails++;
                    $display("FAIL boundary_drive: abc=%b busy=%b required 000 1", {a1, b1, c1}, busy1);
                end
            end
            if (done1) break;
        end
        checks++;
        if (n !== 4 || pass1 !== 1'b1 || err1 !== 4'd0 || lfv1 !== 3'd0) begin
            fails++;
            $display("FAIL boundary_result: cycle=%0d pass=%b err=%0d last=%0d required 4 1 0 0", n, pass1, err1, lfv1);
        end
    endtask

    initial begin
        test_reset();
        test_pass("good_gate", 8'h00, 0);
        test_pass("stuck_at_0", 8'h01, 0);
        test_pass("stuck_at_1", 8'hFE, 0);
        test_pass("extra_start", 8'h00, 10);
        for (int i = 0; i < 4; i++) begin
            test_pass("random_faults", 8'($urandom), 0);
        end
        test_midrun_reset();
        test_pass("after_reset", 8'h00, 0);
        test_boundary();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
